register_file: RTL

Architectural register file and rename-status table for the out-of-order core. It holds the 32 committed integer values plus, per register, a busy flag and the ROB entry that will produce its next value. It consumes the reorder buffer's commit and dependency-set outputs, and drives the reorder buffer's two operand-lookup ports. It answers the decoder's two source-operand queries with either a value or a ROB tag.

---
 rtl/register_file_pkg.sv | 8 +
 rtl/reg_read_port.sv | 47 ++++
 rtl/register_file.sv | 107 ++++++++++
 3 files changed

// File: rtl/register_file_pkg.sv
// Shared core constants: ROB id width and architectural register geometry.
package register_file_pkg;
  localparam int DEF_ROB_BIT = 4;
  localparam int REG_NUM     = 32;
  localparam int REG_BIT     = 5;
  localparam int XLEN        = 32;
  localparam int NUM_PORTS   = 2;
endpackage

// File: rtl/reg_read_port.sv
// One decoder operand lookup: register value, same-cycle commit forward,
// ROB result forward, or the producing ROB tag.
module reg_read_port
  import register_file_pkg::*;
#(
  parameter int ROB_BIT = DEF_ROB_BIT
) (
  input  logic [REG_NUM-1:0][XLEN-1:0]    regs,
  input  logic [REG_NUM-1:0]              busy,
  input  logic [REG_NUM-1:0][ROB_BIT-1:0] dep,
  input  logic [REG_BIT-1:0]              set_reg_id,
  input  logic [XLEN-1:0]                 set_val,
  input  logic [ROB_BIT-1:0]              set_reg_on_rob_id,
  input  logic [REG_BIT-1:0]              get_id,
  input  logic                            rob_value_ready,
  input  logic [XLEN-1:0]                 rob_value,
  output logic [XLEN-1:0]                 val,
  output logic                            has_dep,
  output logic [ROB_BIT-1:0]              dep_out,
  output logic [ROB_BIT-1:0]              get_rob_id
);

  logic               cur_busy;
  logic [ROB_BIT-1:0] cur_dep;

  always_comb begin
    val        = '0;
    has_dep    = 1'b0;
    dep_out    = '0;
    cur_busy   = busy[get_id];
    cur_dep    = dep[get_id];
    get_rob_id = cur_busy ? cur_dep : '0;
    if (get_id == '0) begin
      val = '0;
    end else if (!cur_busy) begin
      val = regs[get_id];
    end else if (set_reg_id == get_id && set_reg_on_rob_id == cur_dep) begin
      val = set_val;
    end else if (rob_value_ready) begin
      val = rob_value;
    end else begin
      has_dep = 1'b1;
      dep_out = cur_dep;
    end
  end

endmodule

// File: rtl/register_file.sv
// Architectural register file with per-register rename status (busy + ROB tag)
// and two forwarding read ports for the decoder.
module register_file
  import register_file_pkg::*;
#(
  parameter int ROB_BIT = DEF_ROB_BIT
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               clear,
  input  logic [REG_BIT-1:0] set_reg_id,
  input  logic [XLEN-1:0]    set_val,
  input  logic [ROB_BIT-1:0] set_reg_on_rob_id,
  input  logic [REG_BIT-1:0] set_dep_reg_id,
  input  logic [ROB_BIT-1:0] set_dep_rob_id,
  input  logic [REG_BIT-1:0] get_id1,
  input  logic [REG_BIT-1:0] get_id2,
  output logic [XLEN-1:0]    val1,
  output logic [XLEN-1:0]    val2,
  output logic               has_dep1,
  output logic               has_dep2,
  output logic [ROB_BIT-1:0] dep1,
  output logic [ROB_BIT-1:0] dep2,
  output logic [ROB_BIT-1:0] get_rob_id1,
  output logic [ROB_BIT-1:0] get_rob_id2,
  input  logic               rob_value1_ready,
  input  logic               rob_value2_ready,
  input  logic [XLEN-1:0]    rob_value1,
  input  logic [XLEN-1:0]    rob_value2
);

  logic [REG_NUM-1:0][XLEN-1:0]    regs_q, regs_d;
  logic [REG_NUM-1:0]              busy_q, busy_d;
  logic [REG_NUM-1:0][ROB_BIT-1:0] dep_q, dep_d;

  // Commit before rename so a same-cycle rename of the committed register wins.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    dep_d  = dep_q;
    if (clear) begin
      busy_d = '0;
    end else begin
      if (set_reg_id != '0) begin
        regs_d[set_reg_id] = set_val;
        if (dep_q[set_reg_id] == set_reg_on_rob_id) busy_d[set_reg_id] = 1'b0;
      end
      if (set_dep_reg_id != '0) begin
        busy_d[set_dep_reg_id] = 1'b1;
        dep_d[set_dep_reg_id]  = set_dep_rob_id;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      regs_q <= '0;
      busy_q <= '0;
      dep_q  <= '0;
    end else if (rdy_in) begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      dep_q  <= dep_d;
    end
  end

  logic [NUM_PORTS-1:0][REG_BIT-1:0] get_id_p;
  logic [NUM_PORTS-1:0]              rob_rdy_p;
  logic [NUM_PORTS-1:0][XLEN-1:0]    rob_val_p;
  logic [NUM_PORTS-1:0][XLEN-1:0]    val_p;
  logic [NUM_PORTS-1:0]              has_dep_p;
  logic [NUM_PORTS-1:0][ROB_BIT-1:0] dep_p;
  logic [NUM_PORTS-1:0][ROB_BIT-1:0] rob_id_p;

  assign get_id_p  = {get_id2, get_id1};
  assign rob_rdy_p = {rob_value2_ready, rob_value1_ready};
  assign rob_val_p = {rob_value2, rob_value1};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    reg_read_port #(.ROB_BIT(ROB_BIT)) u_port (
      .regs              (regs_q),
      .busy              (busy_q),
      .dep               (dep_q),
      .set_reg_id        (set_reg_id),
      .set_val           (set_val),
      .set_reg_on_rob_id (set_reg_on_rob_id),
      .get_id            (get_id_p[p]),
      .rob_value_ready   (rob_rdy_p[p]),
      .rob_value         (rob_val_p[p]),
      .val               (val_p[p]),
      .has_dep           (has_dep_p[p]),
      .dep_out           (dep_p[p]),
      .get_rob_id        (rob_id_p[p])
    );
  end

  assign val1        = val_p[0];
  assign val2        = val_p[1];
  assign has_dep1    = has_dep_p[0];
  assign has_dep2    = has_dep_p[1];
  assign dep1        = dep_p[0];
  assign dep2        = dep_p[1];
  assign get_rob_id1 = rob_id_p[0];
  assign get_rob_id2 = rob_id_p[1];

endmodule
